// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder: access sizes, FSM states
// and byte-lane arithmetic.
package dmem_pkg;

  typedef enum logic [1:0] {
    TAM_B = 2'b00,
    TAM_H = 2'b01,
    TAM_W = 2'b10,
    TAM_D = 2'b11
  } tam_t;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR,
    RMW_RD,
    RMW_WR,
    RSP
  } state_t;

  function automatic logic [3:0] size_bytes(input tam_t tam);
    case (tam)
      TAM_B:   return 4'd1;
      TAM_H:   return 4'd2;
      TAM_W:   return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic [7:0] lane_mask(input tam_t tam, input logic [2:0] lane);
    logic [7:0] base;
    case (tam)
      TAM_B:   base = 8'h01;
      TAM_H:   base = 8'h03;
      TAM_W:   base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << lane;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: merges right-aligned store data into an old word and extracts
// a zero/sign-extended load value from a word.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [63:0] oldWord,
  input  logic [63:0] wdata,
  input  tam_t        tam,
  input  logic [2:0]  lane,
  input  logic        isUnsigned,
  output logic [63:0] mergedWord,
  output logic [63:0] loadValue
);

  logic [7:0]  mask;
  logic [63:0] laneBits;
  logic [63:0] shiftedW;
  logic [63:0] shiftedR;

  always_comb begin
    mask     = lane_mask(tam, lane);
    laneBits = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      laneBits[8*k +: 8] = {8{mask[k]}};
    end
    shiftedW   = wdata << {lane, 3'b000};
    mergedWord = (shiftedW & laneBits) | (oldWord & ~laneBits);

    shiftedR = oldWord >> {lane, 3'b000};
    case (tam)
      TAM_B:   loadValue = isUnsigned ? {56'd0, shiftedR[7:0]}  : {{56{shiftedR[7]}},  shiftedR[7:0]};
      TAM_H:   loadValue = isUnsigned ? {48'd0, shiftedR[15:0]} : {{48{shiftedR[15]}}, shiftedR[15:0]};
      TAM_W:   loadValue = isUnsigned ? {32'd0, shiftedR[31:0]} : {{32{shiftedR[31]}}, shiftedR[31:0]};
      default: loadValue = shiftedR;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the data-memory port: one request at a time, 64-bit
// little-endian RAM, read-modify-write for sub-word stores, error on bad address.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_tam,
  input  logic        req_unsigned,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  logic [63:0] ram [DEPTH_WORDS];

  state_t      state;
  logic [AW-1:0] idx;
  logic [2:0]  lane;
  tam_t        tam;
  logic        isUns;
  logic [63:0] wdata;
  logic [63:0] oldWord;

  logic        accept;
  logic        misaligned;
  logic        outOfRange;
  logic        reqErr;
  logic [63:0] alignOld;
  logic [63:0] mergedWord;
  logic [63:0] loadValue;

  always_comb begin
    accept     = req_valid && req_ready;
    misaligned = (({1'b0, req_addr[2:0]}) & (size_bytes(tam_t'(req_tam)) - 4'd1)) != 4'd0;
    outOfRange = req_addr[63:AW+3] != '0;
    reqErr     = misaligned || outOfRange;
    // Merge uses the word captured in RMW_RD; loads read the array directly in RD.
    alignOld   = (state == RMW_WR) ? oldWord : ram[idx];
  end

  dmem_lane_align u_align (
    .oldWord   (alignOld),
    .wdata     (wdata),
    .tam       (tam),
    .lane      (lane),
    .isUnsigned(isUns),
    .mergedWord(mergedWord),
    .loadValue (loadValue)
  );

  // Datapath and RAM carry no reset; writes are gated by FSM state, so a reset
  // before a write's exit edge leaves the array untouched.
  always_ff @(posedge Clk) begin
    if (accept) begin
      idx   <= req_addr[AW+2:3];
      lane  <= req_addr[2:0];
      tam   <= tam_t'(req_tam);
      isUns <= req_unsigned;
      wdata <= req_wdata;
    end
    if (state == RMW_RD) oldWord <= ram[idx];
    if (state == WR)     ram[idx] <= wdata;
    if (state == RMW_WR) ram[idx] <= mergedWord;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            req_ready <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            if (reqErr) begin
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
              state     <= RSP;
            end else if (!req_write) begin
              state <= RD;
            end else if (tam_t'(req_tam) == TAM_D) begin
              state <= WR;
            end else begin
              state <= RMW_RD;
            end
          end
        end
        RD: begin
          rsp_rdata <= loadValue;
          rsp_valid <= 1'b1;
          state     <= RSP;
        end
        WR: begin
          rsp_valid <= 1'b1;
          state     <= RSP;
        end
        RMW_RD: state <= RMW_WR;
        RMW_WR: begin
          rsp_valid <= 1'b1;
          state     <= RSP;
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder: a byte-array memory model predicts every
// response and its timing; directed steps pin the model with literal values.
module tb_dmem_responder;

  localparam int DEPTH = 16;

  logic        Clk;
  logic        Reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_tam;
  logic        req_unsigned;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  dmem_responder #(.DEPTH_WORDS(DEPTH)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_tam     (req_tam),
    .req_unsigned(req_unsigned),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic timeoutFail(input string name);
    total++;
    bad++;
    $display("FAIL %s actual=timeout required=event t=%0t", name, $time);
  endtask

  // Behavioural model: byte-addressed memory plus one outstanding transaction.
  logic [7:0]      mem [0:DEPTH*8-1];
  bit              busy  = 0;
  int              since = 0;
  int              lat   = 1;
  logic [63:0]     eRd   = '0;
  logic            eErr  = 1'b0;
  bit              pendW = 0;
  longint unsigned pA;
  logic [63:0]     pD;
  int              pSize;

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      busy  = 0;
      pendW = 0;
    end else if (!busy) begin
      if (req_valid) begin
        int size;
        longint unsigned a;
        size  = 1 << req_tam;
        a     = req_addr;
        busy  = 1;
        since = 0;
        pendW = 0;
        eRd   = '0;
        eErr  = 1'b0;
        if ((a % size) != 0 || a >= DEPTH * 8) begin
          eErr = 1'b1;
          lat  = 1;
        end else if (req_write) begin
          lat   = (size == 8) ? 2 : 3;
          pendW = 1;
          pA    = a;
          pD    = req_wdata;
          pSize = size;
        end else begin
          lat = 2;
          for (int i = 0; i < size; i++) eRd |= 64'(mem[a + i]) << (8 * i);
          if (!req_unsigned && size < 8 && eRd[8*size-1])
            eRd |= ~((64'd1 << (8 * size)) - 64'd1);
        end
      end
    end else if (since >= lat - 1 && rsp_ready) begin
      busy = 0;
    end else begin
      since++;
      if (pendW && since == lat - 1) begin
        for (int i = 0; i < pSize; i++) mem[pA + i] = pD[8*i +: 8];
        pendW = 0;
      end
    end
  end

  always @(negedge Clk) begin
    logic expV;
    expV = busy && (since >= lat - 1);
    chk("rspValid", rsp_valid, expV);
    chk("reqReady", req_ready, !busy);
    if (expV) begin
      chk("rspRdata", rsp_rdata, eRd);
      chk("rspErr", rsp_err, eErr);
    end
  end

  logic [63:0] lastRdata;
  logic        lastErr;
  int          lastLat;

  task automatic doReq(input logic w, input logic [1:0] t, input logic u,
                       input logic [63:0] a, input logic [63:0] d, input int hold);
    int n;
    @(negedge Clk);
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge Clk);
      n++;
    end
    if (!req_ready) timeoutFail("acceptWait");
    req_valid    = 1'b1;
    req_write    = w;
    req_tam      = t;
    req_unsigned = u;
    req_addr     = a;
    req_wdata    = d;
    @(posedge Clk);
    #1;
    req_valid    = 1'b0;
    req_write    = 1'($urandom);
    req_tam      = 2'($urandom);
    req_unsigned = 1'($urandom);
    req_addr     = {$urandom, $urandom};
    req_wdata    = {$urandom, $urandom};
    lastLat = 0;
    do begin
      @(negedge Clk);
      lastLat++;
    end while (!rsp_valid && lastLat < 20);
    if (!rsp_valid) timeoutFail("rspWait");
    lastRdata = rsp_rdata;
    lastErr   = rsp_err;
    repeat (hold) begin
      @(negedge Clk);
      chk("holdValid", rsp_valid, 1'b1);
      chk("holdReqReady", req_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    @(posedge Clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge Clk);
    chk("postHsReqReady", req_ready, 1'b1);
    chk("postHsValid", rsp_valid, 1'b0);
  endtask

  initial begin
    Reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_tam = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    repeat (2) @(negedge Clk);
    chk("rstValid", rsp_valid, 1'b0);
    chk("rstReqReady", req_ready, 1'b1);
    chk("rstRdata", rsp_rdata, 64'd0);
    chk("rstErr", rsp_err, 1'b0);
    Reset = 1'b0;

    for (int w = 0; w < DEPTH; w++) doReq(1'b1, 2'b11, 1'b0, 64'(w * 8), {$urandom, $urandom}, 0);

    doReq(1'b1, 2'b11, 1'b0, 64'h10, 64'h0123456789ABCDEF, 0);
    chk("stDLat", 64'(lastLat), 64'd2);
    chk("stDErr", lastErr, 1'b0);
    doReq(1'b0, 2'b11, 1'b0, 64'h10, '0, 0);
    chk("ldDData", lastRdata, 64'h0123456789ABCDEF);
    chk("ldDLat", 64'(lastLat), 64'd2);
    doReq(1'b1, 2'b00, 1'b0, 64'h13, 64'hAA, 0);
    chk("stBLat", 64'(lastLat), 64'd3);
    doReq(1'b0, 2'b11, 1'b0, 64'h10, '0, 0);
    chk("ldAfterStB", lastRdata, 64'h01234567AAABCDEF);
    doReq(1'b0, 2'b00, 1'b0, 64'h13, '0, 0);
    chk("ldBSigned", lastRdata, 64'hFFFFFFFFFFFFFFAA);
    doReq(1'b0, 2'b00, 1'b1, 64'h13, '0, 0);
    chk("ldBUnsigned", lastRdata, 64'h00000000000000AA);
    doReq(1'b0, 2'b01, 1'b0, 64'h16, '0, 0);
    chk("ldHSigned", lastRdata, 64'h0000000000000123);
    doReq(1'b0, 2'b10, 1'b0, 64'h12, '0, 0);
    chk("misErr", lastErr, 1'b1);
    chk("misData", lastRdata, 64'd0);
    chk("misLat", 64'(lastLat), 64'd1);
    doReq(1'b0, 2'b11, 1'b0, 64'(DEPTH * 8), '0, 0);
    chk("oorErr", lastErr, 1'b1);
    chk("oorLat", 64'(lastLat), 64'd1);
    doReq(1'b1, 2'b10, 1'b0, 64'h12, 64'hDEADBEEF, 0);
    chk("misStErr", lastErr, 1'b1);
    doReq(1'b0, 2'b11, 1'b0, 64'h10, '0, 5);
    chk("unchanged", lastRdata, 64'h01234567AAABCDEF);

    doReq(1'b1, 2'b11, 1'b0, 64'h20, 64'h1111111111111111, 0);
    @(negedge Clk);
    req_valid = 1'b1; req_write = 1'b1; req_tam = 2'b01; req_unsigned = 1'b0;
    req_addr = 64'h20; req_wdata = 64'hBEEF;
    @(posedge Clk);
    #1 req_valid = 1'b0;
    #1 Reset = 1'b1;
    #1;
    chk("midRstValid", rsp_valid, 1'b0);
    chk("midRstReqReady", req_ready, 1'b1);
    chk("midRstRdata", rsp_rdata, 64'd0);
    chk("midRstErr", rsp_err, 1'b0);
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    doReq(1'b0, 2'b11, 1'b0, 64'h20, '0, 0);
    chk("rstNoWrite", lastRdata, 64'h1111111111111111);

    for (int r = 0; r < 300; r++) begin
      logic [1:0]  t;
      logic [63:0] a;
      int          sz;
      int          ln;
      int          k;
      t  = 2'($urandom);
      sz = 1 << t;
      ln = $urandom_range(0, 7);
      if ($urandom_range(0, 7) != 0) ln = ln & ~(sz - 1);
      a  = 64'($urandom_range(0, DEPTH - 1) * 8 + ln);
      k  = $urandom_range(0, 9);
      if (k == 0) a = a + 64'(DEPTH * 8 * $urandom_range(1, 3));
      if (k == 1) a[45] = 1'b1;
      doReq(1'($urandom_range(0, 1)), t, 1'($urandom_range(0, 1)), a,
            {$urandom, $urandom}, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Memory-side responder for the processor's data-memory port. It accepts one load/store request at a time over a valid/ready handshake and holds a DEPTH_WORDS x 64-bit little-endian RAM. Sub-word stores are done as read-modify-write. Loads return zero- or sign-extended data over a valid/ready response channel, and misaligned or out-of-range accesses are rejected with an error flag.

Parameters:
DEPTH_WORDS, 256, number of 64-bit words; power of two, at least 2
AW, $clog2(DEPTH_WORDS), word-index width (derived; not overridable)

Ports:
Clk  in  1  clock; all state updates on rising edge
Reset  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  responder can accept; high only in IDLE
req_write  in  1  1 = store, 0 = load
req_tam  in  2  access size: 00 byte, 01 half, 10 word, 11 double
req_unsigned  in  1  load only: 1 = zero-extend, 0 = sign-extend
req_addr  in  64  byte address
req_wdata  in  64  store data, right-aligned (bits [8*size-1:0] used)
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_rdata  out  64  extended load data; 0 for stores and errors
rsp_err  out  1  request was misaligned or out of range

Behaviour:
- One clock (Clk). Reset is asynchronous and active-high (Reset).
- On Reset: state IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_err=0. RAM contents are not cleared.
- A request is accepted on a rising edge with req_valid & req_ready. All request fields are latched on that edge, so inputs may change afterwards.
- Size in bytes: 1 << req_tam.
- Error check at accept:
  - misaligned if (addr mod size) != 0;
  - out of range if addr >= DEPTH_WORDS*8.
- Word index: addr[AW+2:3]. Byte lane: addr[2:0]. Byte k of a word occupies bits [8k+7:8k].
- FSM states: IDLE, RD, WR, RMW_RD, RMW_WR, RSP.
  - IDLE --accept, error--> RSP, with rsp_err=1 and no memory access.
  - IDLE --accept, load--> RD. RAM is read synchronously; the word is captured at the end of RD. Then RD --> RSP.
  - IDLE --accept, store, tam=11--> WR. The full word is written on the WR exit edge. Then WR --> RSP.
  - IDLE --accept, store, tam<11--> RMW_RD. Old word is read. Then RMW_RD --> RMW_WR. The merged word (new bytes in the addressed lanes, other lanes kept) is written on the RMW_WR exit edge. Then RMW_WR --> RSP.
  - RSP: rsp_valid=1, outputs stable. RSP --rsp_ready--> IDLE on that edge, and rsp_valid drops.
- Latency from accept edge to first cycle with rsp_valid high:
  - error: 1
  - load: 2
  - 64-bit store: 2
  - narrow store: 3
- req_ready is low from the accept edge until the cycle after the response handshake. No back-to-back accept happens in the response-handshake cycle.
- Load data: extract size bytes starting at the lane, then extend to 64 bits (zero- or sign-extend per req_unsigned). For tam=11, req_unsigned is ignored.
- Stores return rsp_rdata=0 and rsp_err=0.
- Reset mid-operation: return to IDLE immediately. A write not yet reached by its exit edge is not performed; RAM holds its old value.
- Store followed by load to the same word returns the updated data (the write completes before RSP).

Decomposition:
- Package dmem_pkg:
  - tam_t enum (TAM_B, TAM_H, TAM_W, TAM_D);
  - state_t enum for the six states;
  - function size_bytes(tam_t);
  - function lane_mask(tam_t, lane) returning an 8-bit byte-enable.
- Sub-module dmem_lane_align (combinational):
  - inputs: old word, wdata, tam, lane, unsigned;
  - outputs: merged store word and extended load value.
- The FSM and RAM array stay in dmem_responder.

Test Plan:
- Store double 0x0123456789ABCDEF at addr 0x10, then load double at 0x10 -> rsp_rdata=0x0123456789ABCDEF; rsp_valid 2 cycles after each accept; rsp_err=0.
- Store byte 0xAA at addr 0x13 over that word, then load double at 0x10 -> 0x01234567AAABCDEF; store response appears 3 cycles after accept.
- Load byte at 0x13: signed -> 0xFFFFFFFFFFFFFFAA; unsigned -> 0x00000000000000AA. Load half at 0x16, signed -> 0x0000000000000123.
- Load word at addr 0x12 (misaligned) and load at DEPTH_WORDS*8 -> rsp_err=1 and rsp_rdata=0, 1 cycle after accept; a following load of 0x10 shows memory unchanged.
- Hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stay stable and req_ready stays 0; assert rsp_ready -> IDLE next cycle and req_ready=1.
- Assert Reset during RMW_RD of a half store to 0x20 (word previously 0x1111111111111111) -> outputs immediately at reset values; a later load double at 0x20 returns 0x1111111111111111.
